mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter XLEN, 64, data/address width.
REQ-002 SHALL have parameter ILEN, 32, instruction width.
REQ-003 SHALL have ports:
- clock  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- flush  in  1  kill the in-flight entry.
- in_valid  in  1  EX/MEM register holds a valid op.
- in_ready  out  1  op accepted this cycle.
- ex_pc  in  XLEN  op PC.
- ex_instr  in  ILEN  op instruction.
- ex_w_ena  in  1  regfile write enable.
- ex_w_addr  in  5  destination register.
- ex_alu_result  in  XLEN  ALU result, or effective address for memory ops.
- ex_mem_rd  in  1  load.
- ex_mem_wr  in  1  store.
- ex_mem_size  in  2  0=B, 1=H, 2=W, 3=D.
- ex_mem_unsigned  in  1  zero-extend load.
- ex_store_data  in  XLEN  store data, LSB-aligned.
- dmem_req_valid  out  1  bus request.
- dmem_req_ready  in  1  bus accepts request.
- dmem_req_addr  out  XLEN  {addr[XLEN-1:3], 3'b0}.
- dmem_req_wen  out  1  write request.
- dmem_req_wdata  out  XLEN  lane-shifted store data.
- dmem_req_wstrb  out  8  byte strobes.
- dmem_resp_valid  in  1  response (load data or store ack).
- dmem_resp_rdata  in  XLEN  aligned 8-byte read data.
- out_valid  out  1  MEM result valid for mem_wb.
- out_ready  in  1  mem_wb takes result (its mem_ready).
- MEM_pc / MEM_instr / MEM_w_ena / MEM_w_addr / MEM_w_data  out  XLEN/ILEN/1/5/XLEN  result fields.
- stall_req  out  1  upstream hold request.

Function
REQ-004 SHALL implement FSM IDLE, REQ, WAIT, DONE, DRAIN.
REQ-005 in_ready SHALL be 1 in IDLE, and in DONE when out_ready=1 (no bubble); 0 otherwise; stall_req SHALL equal in_valid & ~in_ready.
REQ-006 On accept of a non-memory op, SHALL go to DONE next cycle with MEM_w_data=ex_alu_result; latency 1 cycle.
REQ-007 On accept of a load or store, SHALL latch all fields and go to REQ; dmem_req_valid=1 only in REQ, with request fields stable until dmem_req_ready.
REQ-008 REQ -> WAIT on dmem_req_valid & dmem_req_ready; WAIT -> DONE on dmem_resp_valid. A response in the handshake cycle itself SHALL be ignored.
REQ-009 Load data SHALL be dmem_resp_rdata >> (addr[2:0]*8), truncated to size, then sign- or zero-extended per ex_mem_unsigned; size D ignores it.
REQ-010 Store wstrb SHALL be 8'h01/8'h03/8'h0F/8'hFF << addr[2:0] for B/H/W/D; wdata SHALL be ex_store_data << (addr[2:0]*8); misalignment across 8 bytes is undefined and not checked.
REQ-011 Stores SHALL complete on dmem_resp_valid with MEM_w_ena=0.
REQ-012 out_valid SHALL be 1 exactly in DONE; outputs SHALL hold while out_valid & ~out_ready.
REQ-013 DONE & out_ready & ~in_valid SHALL go to IDLE; with in_valid, SHALL accept the new op in the same cycle, per REQ-006/007.
REQ-014 flush in IDLE/REQ/DONE SHALL go to IDLE and drop the entry; an in-flight REQ is withdrawn next cycle. Flush in the cycle of a REQ handshake SHALL go to DRAIN.
REQ-015 flush in WAIT SHALL go to DRAIN; DRAIN discards one dmem_resp_valid and then goes to IDLE. in_ready=0 and out_valid=0 in DRAIN.
REQ-016 flush SHALL override a simultaneous accept; no op is accepted in a flush cycle.
REQ-017 In IDLE/REQ/WAIT/DRAIN: MEM_w_ena=0, MEM_pc=0, MEM_instr=NONE_INST.

Reset
REQ-018 reset SHALL force IDLE and set dmem_req_valid=0, out_valid=0, MEM_w_ena=0, MEM_w_addr=0, MEM_w_data=0, MEM_pc=0, MEM_instr=NONE_INST. It takes priority over flush.
REQ-019 reset mid-transaction SHALL abandon the transaction without draining; the bus is reset together with the block.

Structure
REQ-020 Size encodings, FSM state encoding, NONE_INST and the ZERO_* constants SHALL live in the shared defines package.
REQ-021 Load alignment and extension SHALL be a combinational sub-module, mem_load_align.

Verification
REQ-022 ALU op 0x1234, rd=5, out_ready=1 -> out_valid next cycle, MEM_w_data=0x1234, MEM_w_ena=1.
REQ-023 LB at addr 0x...0003, rdata 0x0000_0000_8000_0000, signed -> MEM_w_data=0xFFFF_FFFF_FFFF_FF80; LBU -> 0x80.
REQ-024 SH at addr 0x...0006, data 0xBEEF -> wstrb=0xC0, wdata=0xBEEF_0000_0000_0000; done with MEM_w_ena=0.
REQ-025 dmem_req_ready low for 3 cycles -> req_valid and addr held; stall_req=1 with in_valid; one result only.
REQ-026 flush in WAIT, response 2 cycles later -> no out_valid; the next load gets its own data, not the stale data.
REQ-027 out_ready=0 for 4 cycles in DONE -> outputs stable; on release a queued ALU op is accepted the same cycle and is valid next cycle.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM states, idle
// instruction marker and zero constants.
package mem_lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } mem_size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } lsu_state_e;

  localparam logic [31:0] NONE_INST = 32'h0000_0013;
  localparam logic [63:0] ZERO_WORD = 64'd0;
  localparam logic [4:0]  ZERO_REG  = 5'd0;

  // Byte-enable pattern for an access of the given size at lane 0.
  function automatic logic [7:0] size_strb(input logic [1:0] size);
    case (mem_size_e'(size))
      SIZE_B:  size_strb = 8'h01;
      SIZE_H:  size_strb = 8'h03;
      SIZE_W:  size_strb = 8'h0F;
      default: size_strb = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Extracts a load result from an aligned 8-byte bus word: shift the addressed
// lane down, truncate to the access size, then sign- or zero-extend.
module mem_load_align
  import mem_lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      offset,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    data    = shifted;
    case (mem_size_e'(size))
      SIZE_B:  data = {{(XLEN-8){shifted[7] & ~is_unsigned}}, shifted[7:0]};
      SIZE_H:  data = {{(XLEN-16){shifted[15] & ~is_unsigned}}, shifted[15:0]};
      SIZE_W:  data = {{(XLEN-32){shifted[31] & ~is_unsigned}}, shifted[31:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM stage load/store unit: one entry in flight, drives the data bus for
// loads/stores and passes ALU results through with one cycle of latency.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [ILEN-1:0] ex_instr,
  input  logic            ex_w_ena,
  input  logic [4:0]      ex_w_addr,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic            ex_mem_rd,
  input  logic            ex_mem_wr,
  input  logic [1:0]      ex_mem_size,
  input  logic            ex_mem_unsigned,
  input  logic [XLEN-1:0] ex_store_data,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic [XLEN-1:0] dmem_req_addr,
  output logic            dmem_req_wen,
  output logic [XLEN-1:0] dmem_req_wdata,
  output logic [7:0]      dmem_req_wstrb,
  input  logic            dmem_resp_valid,
  input  logic [XLEN-1:0] dmem_resp_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] MEM_pc,
  output logic [ILEN-1:0] MEM_instr,
  output logic            MEM_w_ena,
  output logic [4:0]      MEM_w_addr,
  output logic [XLEN-1:0] MEM_w_data,
  output logic            stall_req,
  output lsu_state_e      fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid and its payload hold until then, ready may change freely.
  lsu_state_e      state;
  logic [XLEN-1:0] pc_q;
  logic [ILEN-1:0] instr_q;
  logic            w_ena_q;
  logic [4:0]      w_addr_q;
  logic            is_store_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [2:0]      offset_q;
  logic [XLEN-1:0] load_data;
  logic            is_mem;
  logic            accept;

  assign is_mem    = ex_mem_rd | ex_mem_wr;
  assign in_ready  = ~flush & ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign stall_req = in_valid & ~in_ready;

  assign dmem_req_valid = (state == REQ);
  assign dmem_req_wen   = is_store_q;
  assign out_valid      = (state == DONE);
  assign fsm_state      = state;

  mem_load_align #(.XLEN(XLEN)) u_align (
    .rdata       (dmem_resp_rdata),
    .offset      (offset_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (load_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      MEM_pc     <= XLEN'(ZERO_WORD);
      MEM_instr  <= ILEN'(NONE_INST);
      MEM_w_ena  <= 1'b0;
      MEM_w_addr <= ZERO_REG;
      MEM_w_data <= XLEN'(ZERO_WORD);
    end else if (flush) begin
      // A request already handed to the bus leaves one response to discard.
      case (state)
        REQ:     state <= dmem_req_ready ? DRAIN : IDLE;
        WAIT:    state <= DRAIN;
        DRAIN:   state <= dmem_resp_valid ? IDLE : DRAIN;
        default: state <= IDLE;
      endcase
      MEM_pc    <= XLEN'(ZERO_WORD);
      MEM_instr <= ILEN'(NONE_INST);
      MEM_w_ena <= 1'b0;
    end else if (accept) begin
      pc_q           <= ex_pc;
      instr_q        <= ex_instr;
      w_ena_q        <= ex_w_ena;
      w_addr_q       <= ex_w_addr;
      is_store_q     <= ex_mem_wr;
      size_q         <= ex_mem_size;
      uns_q          <= ex_mem_unsigned;
      offset_q       <= ex_alu_result[2:0];
      dmem_req_addr  <= {ex_alu_result[XLEN-1:3], 3'b000};
      dmem_req_wstrb <= size_strb(ex_mem_size) << ex_alu_result[2:0];
      dmem_req_wdata <= ex_store_data << {ex_alu_result[2:0], 3'b000};
      if (is_mem) begin
        state     <= REQ;
        MEM_pc    <= XLEN'(ZERO_WORD);
        MEM_instr <= ILEN'(NONE_INST);
        MEM_w_ena <= 1'b0;
      end else begin
        state      <= DONE;
        MEM_pc     <= ex_pc;
        MEM_instr  <= ex_instr;
        MEM_w_ena  <= ex_w_ena;
        MEM_w_addr <= ex_w_addr;
        MEM_w_data <= ex_alu_result;
      end
    end else begin
      case (state)
        REQ: if (dmem_req_ready) state <= WAIT;
        WAIT: begin
          if (dmem_resp_valid) begin
            state      <= DONE;
            MEM_pc     <= pc_q;
            MEM_instr  <= instr_q;
            MEM_w_ena  <= w_ena_q & ~is_store_q;
            MEM_w_addr <= w_addr_q;
            MEM_w_data <= is_store_q ? XLEN'(ZERO_WORD) : load_data;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            MEM_pc    <= XLEN'(ZERO_WORD);
            MEM_instr <= ILEN'(NONE_INST);
            MEM_w_ena <= 1'b0;
          end
        end
        DRAIN: if (dmem_resp_valid) state <= IDLE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: results are predicted into a queue when ops are
// driven and compared when the unit hands them to the writeback stage.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam int EW   = 135;  // {store, w_ena, w_addr[4:0], w_data[63:0], pc[63:0]}

  logic            clock = 1'b0;
  logic            reset, flush, in_valid, in_ready;
  logic [XLEN-1:0] ex_pc, ex_alu_result, ex_store_data;
  logic [ILEN-1:0] ex_instr;
  logic            ex_w_ena, ex_mem_rd, ex_mem_wr, ex_mem_unsigned;
  logic [4:0]      ex_w_addr;
  logic [1:0]      ex_mem_size;
  logic            dmem_req_valid, dmem_req_ready, dmem_req_wen;
  logic [XLEN-1:0] dmem_req_addr, dmem_req_wdata, dmem_resp_rdata;
  logic [7:0]      dmem_req_wstrb;
  logic            dmem_resp_valid, out_valid, out_ready;
  logic [XLEN-1:0] MEM_pc, MEM_w_data;
  logic [ILEN-1:0] MEM_instr;
  logic            MEM_w_ena, stall_req;
  logic [4:0]      MEM_w_addr;
  lsu_state_e      fsm_state;

  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  always #5 clock = ~clock;

  mem_lsu #(.XLEN(XLEN), .ILEN(ILEN)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .ex_pc(ex_pc), .ex_instr(ex_instr), .ex_w_ena(ex_w_ena), .ex_w_addr(ex_w_addr),
    .ex_alu_result(ex_alu_result), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned), .ex_store_data(ex_store_data),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_addr(dmem_req_addr), .dmem_req_wen(dmem_req_wen),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_wstrb(dmem_req_wstrb),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .MEM_pc(MEM_pc), .MEM_instr(MEM_instr), .MEM_w_ena(MEM_w_ena),
    .MEM_w_addr(MEM_w_addr), .MEM_w_data(MEM_w_data),
    .stall_req(stall_req), .fsm_state(fsm_state)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  function automatic logic [31:0] instr_of(input logic [63:0] pc);
    return {pc[15:0], 16'h0033};
  endfunction

  task automatic send_alu(input logic [63:0] pc, input logic [63:0] res, input logic [4:0] rd);
    in_valid = 1'b1; ex_pc = pc; ex_instr = instr_of(pc); ex_w_ena = 1'b1; ex_w_addr = rd;
    ex_alu_result = res; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0; ex_mem_size = 2'd0;
    ex_mem_unsigned = 1'b0; ex_store_data = '0;
  endtask

  task automatic send_mem(input logic [63:0] pc, input logic [63:0] addr, input logic wr,
                          input logic [1:0] size, input logic uns, input logic [63:0] sdata,
                          input logic [4:0] rd);
    in_valid = 1'b1; ex_pc = pc; ex_instr = instr_of(pc); ex_w_ena = 1'b1; ex_w_addr = rd;
    ex_alu_result = addr; ex_mem_rd = ~wr; ex_mem_wr = wr; ex_mem_size = size;
    ex_mem_unsigned = uns; ex_store_data = sdata;
  endtask

  task automatic push(input logic st, input logic we, input logic [4:0] rd,
                      input logic [63:0] data, input logic [63:0] pc);
    exp_q.push_back({st, we, rd, data, pc});
  endtask

  // Called one cycle after a memory op is accepted; returns in the DONE cycle.
  task automatic bus_txn(input string tag, input int ready_wait, input int resp_wait,
                         input bit stray, input logic [63:0] rdata, input logic [63:0] addr);
    for (int i = 0; i < ready_wait; i++) begin
      dmem_req_ready = 1'b0;
      #1;
      chk({tag, "_req_valid_hold"}, dmem_req_valid, 1);
      chk({tag, "_req_addr_hold"}, dmem_req_addr, addr);
      chk({tag, "_stall"}, stall_req, in_valid);
      chk({tag, "_in_ready_busy"}, in_ready, 0);
      tick();
    end
    dmem_req_ready = 1'b1;
    if (stray) begin
      dmem_resp_valid = 1'b1;
      dmem_resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    end
    #1;
    chk({tag, "_req_valid"}, dmem_req_valid, 1);
    chk({tag, "_req_addr"}, dmem_req_addr, addr);
    tick();
    dmem_req_ready = 1'b0;
    dmem_resp_valid = 1'b0;
    for (int i = 0; i < resp_wait; i++) begin
      #1;
      chk({tag, "_wait_req_valid"}, dmem_req_valid, 0);
      chk({tag, "_wait_out_valid"}, out_valid, 0);
      tick();
    end
    dmem_resp_valid = 1'b1;
    dmem_resp_rdata = rdata;
    tick();
    dmem_resp_valid = 1'b0;
    #1;
    chk({tag, "_done_out_valid"}, out_valid, 1);
  endtask

  // Scoreboard: compare each result at the point writeback takes it.
  always @(negedge clock) begin
    logic [EW-1:0] e;
    #2;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk("res_pc", MEM_pc, e[63:0]);
        chk("res_w_ena", MEM_w_ena, e[133]);
        if (!e[134]) begin
          chk("res_w_data", MEM_w_data, e[127:64]);
          chk("res_w_addr", MEM_w_addr, e[132:128]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    send_alu(64'h0, 64'h0, 5'd0); in_valid = 1'b0;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_resp_rdata = '0;
    tick(); tick();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req_valid", dmem_req_valid, 0);
    chk("rst_w_ena", MEM_w_ena, 0);
    chk("rst_w_addr", MEM_w_addr, 0);
    chk("rst_w_data", MEM_w_data, 0);
    chk("rst_pc", MEM_pc, 0);
    chk("rst_instr", MEM_instr, 32'h0000_0013);
    chk("rst_state", fsm_state, IDLE);
    reset = 1'b0;

    // ALU pass-through, one cycle latency.
    tick();
    send_alu(64'h100, 64'h1234, 5'd5);
    #1;
    chk("alu_in_ready", in_ready, 1);
    chk("alu_stall", stall_req, 0);
    push(1'b0, 1'b1, 5'd5, 64'h1234, 64'h100);
    tick(); in_valid = 1'b0;
    #1;
    chk("alu_out_valid", out_valid, 1);
    chk("alu_w_data", MEM_w_data, 64'h1234);
    chk("alu_w_ena", MEM_w_ena, 1);
    chk("alu_instr", MEM_instr, instr_of(64'h100));
    tick();
    #1;
    chk("idle_out_valid", out_valid, 0);
    chk("idle_instr", MEM_instr, 32'h0000_0013);
    chk("idle_pc", MEM_pc, 0);

    // LB signed at offset 3, with a stray response in the handshake cycle.
    tick();
    send_mem(64'h200, 64'h1000_0003, 1'b0, 2'd0, 1'b0, 64'h0, 5'd7);
    push(1'b0, 1'b1, 5'd7, 64'hFFFF_FFFF_FFFF_FF80, 64'h200);
    tick(); in_valid = 1'b0;
    #1;
    chk("lb_wen", dmem_req_wen, 0);
    bus_txn("lb", 0, 1, 1'b1, 64'h0000_0000_8000_0000, 64'h1000_0000);
    chk("lb_data", MEM_w_data, 64'hFFFF_FFFF_FFFF_FF80);
    tick();

    // LBU at the same address.
    send_mem(64'h204, 64'h1000_0003, 1'b0, 2'd0, 1'b1, 64'h0, 5'd8);
    push(1'b0, 1'b1, 5'd8, 64'h80, 64'h204);
    tick(); in_valid = 1'b0;
    bus_txn("lbu", 1, 0, 1'b0, 64'h0000_0000_8000_0000, 64'h1000_0000);
    chk("lbu_data", MEM_w_data, 64'h80);
    tick();

    // SH at offset 6.
    send_mem(64'h300, 64'h2000_0006, 1'b1, 2'd1, 1'b0, 64'hBEEF, 5'd9);
    push(1'b1, 1'b0, 5'd9, 64'h0, 64'h300);
    tick(); in_valid = 1'b0;
    #1;
    chk("sh_wstrb", dmem_req_wstrb, 8'hC0);
    chk("sh_wdata", dmem_req_wdata, 64'hBEEF_0000_0000_0000);
    chk("sh_wen", dmem_req_wen, 1);
    bus_txn("sh", 0, 0, 1'b0, 64'h0, 64'h2000_0000);
    chk("sh_w_ena", MEM_w_ena, 0);
    tick();

    // LW with bus backpressure and a queued ALU op taken without a bubble.
    send_mem(64'h400, 64'h3000_0004, 1'b0, 2'd2, 1'b0, 64'h0, 5'd11);
    push(1'b0, 1'b1, 5'd11, 64'hFFFF_FFFF_8765_4321, 64'h400);
    tick();
    send_alu(64'h404, 64'h55, 5'd3);
    bus_txn("lw", 3, 1, 1'b0, 64'h8765_4321_0000_0000, 64'h3000_0000);
    chk("lw_data", MEM_w_data, 64'hFFFF_FFFF_8765_4321);
    chk("lw_next_in_ready", in_ready, 1);
    chk("lw_next_stall", stall_req, 0);
    push(1'b0, 1'b1, 5'd3, 64'h55, 64'h404);
    tick(); in_valid = 1'b0;
    #1;
    chk("queued_out_valid", out_valid, 1);
    chk("queued_w_data", MEM_w_data, 64'h55);
    tick();

    // Flush in WAIT: the stale response is drained, the next load is clean.
    send_mem(64'h500, 64'h4000_0000, 1'b0, 2'd3, 1'b0, 64'h0, 5'd12);
    tick(); in_valid = 1'b0; dmem_req_ready = 1'b1;
    tick(); dmem_req_ready = 1'b0;
    #1;
    chk("fw_state_wait", fsm_state, WAIT);
    flush = 1'b1;
    tick(); flush = 1'b0;
    #1;
    chk("fw_state_drain", fsm_state, DRAIN);
    chk("fw_drain_in_ready", in_ready, 0);
    chk("fw_drain_out_valid", out_valid, 0);
    tick();
    dmem_resp_valid = 1'b1; dmem_resp_rdata = 64'hDEAD_BEEF_0BAD_F00D;
    tick(); dmem_resp_valid = 1'b0;
    #1;
    chk("fw_state_idle", fsm_state, IDLE);
    chk("fw_out_valid", out_valid, 0);
    send_mem(64'h600, 64'h4000_0008, 1'b0, 2'd3, 1'b0, 64'h0, 5'd13);
    push(1'b0, 1'b1, 5'd13, 64'h1122_3344_5566_7788, 64'h600);
    tick(); in_valid = 1'b0;
    bus_txn("ld2", 0, 0, 1'b0, 64'h1122_3344_5566_7788, 64'h4000_0008);
    chk("ld2_data", MEM_w_data, 64'h1122_3344_5566_7788);
    tick();

    // Flush in REQ without handshake withdraws the request.
    send_mem(64'h700, 64'h5000_0000, 1'b0, 2'd0, 1'b1, 64'h0, 5'd14);
    tick(); in_valid = 1'b0; flush = 1'b1;
    tick(); flush = 1'b0;
    #1;
    chk("fr_req_valid", dmem_req_valid, 0);
    chk("fr_state", fsm_state, IDLE);

    // Flush in the REQ handshake cycle drains one response.
    send_mem(64'h800, 64'h5000_0010, 1'b0, 2'd0, 1'b1, 64'h0, 5'd14);
    tick(); in_valid = 1'b0; flush = 1'b1; dmem_req_ready = 1'b1;
    tick(); flush = 1'b0; dmem_req_ready = 1'b0;
    #1;
    chk("frh_state", fsm_state, DRAIN);
    chk("frh_req_valid", dmem_req_valid, 0);
    dmem_resp_valid = 1'b1;
    tick(); dmem_resp_valid = 1'b0;
    #1;
    chk("frh_state_idle", fsm_state, IDLE);

    // Flush overrides a simultaneous accept.
    send_alu(64'h900, 64'h77, 5'd4);
    flush = 1'b1;
    #1;
    chk("fa_in_ready", in_ready, 0);
    chk("fa_stall", stall_req, 1);
    tick(); flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("fa_out_valid", out_valid, 0);
    chk("fa_state", fsm_state, IDLE);

    // Flush in DONE drops the held result.
    send_alu(64'hA00, 64'h88, 5'd6);
    tick(); in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
    #1;
    chk("fd_out_valid_before", out_valid, 1);
    tick(); flush = 1'b0; out_ready = 1'b1;
    #1;
    chk("fd_out_valid", out_valid, 0);
    chk("fd_w_ena", MEM_w_ena, 0);

    // Writeback backpressure for 4 cycles, then a queued op with no bubble.
    send_alu(64'hB00, 64'hAAAA, 5'd8);
    push(1'b0, 1'b1, 5'd8, 64'hAAAA, 64'hB00);
    tick();
    out_ready = 1'b0;
    send_alu(64'hB04, 64'hBBBB, 5'd10);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_w_data", MEM_w_data, 64'hAAAA);
      chk("bp_pc", MEM_pc, 64'hB00);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_stall", stall_req, 1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    push(1'b0, 1'b1, 5'd10, 64'hBBBB, 64'hB04);
    tick(); in_valid = 1'b0;
    #1;
    chk("bp_next_out_valid", out_valid, 1);
    chk("bp_next_w_data", MEM_w_data, 64'hBBBB);
    tick();

    // Reset mid-request wins over flush and abandons the transaction.
    send_mem(64'hC00, 64'h6000_0000, 1'b0, 2'd3, 1'b0, 64'h0, 5'd15);
    tick(); in_valid = 1'b0;
    #1;
    chk("mr_req_valid_before", dmem_req_valid, 1);
    reset = 1'b1; flush = 1'b1;
    tick(); reset = 1'b0; flush = 1'b0;
    #1;
    chk("mr_state", fsm_state, IDLE);
    chk("mr_req_valid", dmem_req_valid, 0);
    chk("mr_w_data", MEM_w_data, 0);
    chk("mr_w_addr", MEM_w_addr, 0);

    tick(); tick();
    #3;
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
